// File: rtl/trax_turn_sequencer.sv
// Turn sequencer for a Trax player: walks the datapath through update, auto-complete,
// copy/shift, choose-move and transmit phases. Optional per-phase watchdog: TRAX_WATCHDOG_EN.
module trax_turn_sequencer #(
  parameter int AC_MAX_ITER = 25,
  parameter int WD_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       end_receive,
  input  logic       color,
  output logic       upd_start,
  input  logic       upd_done,
  output logic       ac_start,
  input  logic       ac_done,
  input  logic       ac_changed,
  output logic       cpy_start,
  input  logic       cpy_done,
  input  logic       grow_down,
  input  logic       grow_right,
  output logic       shd_start,
  input  logic       shd_done,
  output logic       shr_start,
  input  logic       shr_done,
  output logic       chm_start,
  input  logic       chm_done,
  input  logic       chm_none,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       move_sel,
  output logic       first_move,
  output logic [3:0] state,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic       rx_overrun
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_UPD  = 4'd1,
    S_AC   = 4'd2,
    S_CPY  = 4'd3,
    S_SHD  = 4'd4,
    S_SHR  = 4'd5,
    S_CHM  = 4'd6,
    S_TX   = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  localparam int IW = $clog2(AC_MAX_ITER + 1);

  state_t        state_q, state_d, post_board;
  logic          start_q, start_d;
  logic          rx_next_q, rx_prev_q, rx_edge;
  logic [7:0]    round_q, round_d;
  logic          pass_own_q, pass_own_d;
  logic          move_sel_q, move_sel_d;
  logic          first_q, first_d;
  logic [IW-1:0] iter_q, iter_d, iter_inc;
  logic          gd_q, gd_d, gr_q, gr_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          ovr_q, ovr_d;
  logic          done_raw, phase_done;

`ifdef TRAX_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
`else
  logic wd_unused;
  assign wd_unused = (WD_CYCLES > 0);
`endif

  // Only grow_right steers a later state; grow_down is latched alongside for symmetry.
  logic grow_unused;
  assign grow_unused = gd_q;

  assign rx_edge    = rx_next_q & ~rx_prev_q;
  assign iter_inc   = iter_q + 1'b1;
  assign post_board = pass_own_q ? S_TX : S_CHM;
  // A done coinciding with its own start pulse belongs to a previous request.
  assign phase_done = done_raw & ~start_q;

  always_comb begin
    done_raw = 1'b0;
    case (state_q)
      S_UPD:   done_raw = upd_done;
      S_AC:    done_raw = ac_done;
      S_CPY:   done_raw = cpy_done;
      S_SHD:   done_raw = shd_done;
      S_SHR:   done_raw = shr_done;
      S_CHM:   done_raw = chm_done;
      S_TX:    done_raw = tx_done;
      default: done_raw = 1'b0;
    endcase
  end

  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    round_d    = round_q;
    pass_own_d = pass_own_q;
    move_sel_d = move_sel_q;
    first_d    = first_q;
    iter_d     = iter_q;
    gd_d       = gd_q;
    gr_d       = gr_q;
    err_d      = err_q;
    code_d     = code_q;
    ovr_d      = ovr_q | (rx_edge & (state_q != S_IDLE));
`ifdef TRAX_WATCHDOG_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      S_IDLE: if (rx_edge) begin
        if (round_q != 8'hFF) round_d = round_q + 8'd1;
        if (round_q == 8'd0 && !color) begin
          pass_own_d = 1'b1;
          first_d    = 1'b1;
          move_sel_d = 1'b1;
        end else begin
          pass_own_d = 1'b0;
          move_sel_d = 1'b0;
        end
        state_d = S_UPD;
        start_d = 1'b1;
      end
      S_UPD: if (phase_done) begin
        iter_d  = '0;
        state_d = S_AC;
        start_d = 1'b1;
      end
      S_AC: if (phase_done) begin
        iter_d = iter_inc;
        if (!ac_changed) begin
          state_d = S_CPY;
          start_d = 1'b1;
        end else if (iter_inc == IW'(AC_MAX_ITER)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = 2'd1;
        end else begin
          start_d = 1'b1;
        end
      end
      S_CPY: if (phase_done) begin
        gd_d    = grow_down;
        gr_d    = grow_right;
        start_d = 1'b1;
        if (grow_down)       state_d = S_SHD;
        else if (grow_right) state_d = S_SHR;
        else                 state_d = post_board;
      end
      S_SHD: if (phase_done) begin
        state_d = gr_q ? S_SHR : post_board;
        start_d = 1'b1;
      end
      S_SHR: if (phase_done) begin
        state_d = post_board;
        start_d = 1'b1;
      end
      S_CHM: if (phase_done) begin
        if (chm_none) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end else begin
          pass_own_d = 1'b1;
          move_sel_d = 1'b1;
          state_d    = S_UPD;
          start_d    = 1'b1;
        end
      end
      S_TX: if (phase_done) begin
        first_d    = 1'b0;
        move_sel_d = 1'b0;
        state_d    = S_IDLE;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
`ifdef TRAX_WATCHDOG_EN
    if (state_q != S_IDLE && state_q != S_ERR && !phase_done) begin
      wd_d = wd_q + 1'b1;
      if (wd_d == WW'(WD_CYCLES)) begin
        state_d = S_ERR;
        start_d = 1'b0;
        err_d   = 1'b1;
        code_d  = 2'd3;
      end
    end
    if (start_d) wd_d = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      rx_next_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      round_q    <= '0;
      pass_own_q <= 1'b0;
      move_sel_q <= 1'b0;
      first_q    <= 1'b0;
      iter_q     <= '0;
      gd_q       <= 1'b0;
      gr_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      ovr_q      <= 1'b0;
`ifdef TRAX_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      rx_next_q  <= end_receive;
      rx_prev_q  <= rx_next_q;
      round_q    <= round_d;
      pass_own_q <= pass_own_d;
      move_sel_q <= move_sel_d;
      first_q    <= first_d;
      iter_q     <= iter_d;
      gd_q       <= gd_d;
      gr_q       <= gr_d;
      err_q      <= err_d;
      code_q     <= code_d;
      ovr_q      <= ovr_d;
`ifdef TRAX_WATCHDOG_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign upd_start  = start_q & (state_q == S_UPD);
  assign ac_start   = start_q & (state_q == S_AC);
  assign cpy_start  = start_q & (state_q == S_CPY);
  assign shd_start  = start_q & (state_q == S_SHD);
  assign shr_start  = start_q & (state_q == S_SHR);
  assign chm_start  = start_q & (state_q == S_CHM);
  assign tx_start   = start_q & (state_q == S_TX);
  assign move_sel   = move_sel_q;
  assign first_move = first_q;
  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign err_code   = code_q;
  assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_trax_turn_sequencer.sv
// Directed bench for trax_turn_sequencer: expected start pulses are queued by the
// stimulus and popped by a monitor whenever the DUT issues a start.
module tb_trax_turn_sequencer;

  localparam int P_UPD = 0, P_AC = 1, P_CPY = 2, P_SHD = 3, P_SHR = 4, P_CHM = 5, P_TX = 6;

  logic clk = 1'b0, reset = 1'b0, end_receive = 1'b0, color = 1'b0;
  logic upd_done = 1'b0, ac_done = 1'b0, ac_changed = 1'b0, cpy_done = 1'b0;
  logic grow_down = 1'b0, grow_right = 1'b0, shd_done = 1'b0, shr_done = 1'b0;
  logic chm_done = 1'b0, chm_none = 1'b0, tx_done = 1'b0;
  logic upd_start, ac_start, cpy_start, shd_start, shr_start, chm_start, tx_start;
  logic move_sel, first_move, busy, err, rx_overrun;
  logic [3:0] state;
  logic [1:0] err_code;
  logic [6:0] starts;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] starts;
    logic [3:0] st;
    logic       ms;
    logic       fm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  trax_turn_sequencer #(.AC_MAX_ITER(25), .WD_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .end_receive(end_receive), .color(color),
    .upd_start(upd_start), .upd_done(upd_done),
    .ac_start(ac_start), .ac_done(ac_done), .ac_changed(ac_changed),
    .cpy_start(cpy_start), .cpy_done(cpy_done), .grow_down(grow_down), .grow_right(grow_right),
    .shd_start(shd_start), .shd_done(shd_done),
    .shr_start(shr_start), .shr_done(shr_done),
    .chm_start(chm_start), .chm_done(chm_done), .chm_none(chm_none),
    .tx_start(tx_start), .tx_done(tx_done),
    .move_sel(move_sel), .first_move(first_move), .state(state), .busy(busy),
    .err(err), .err_code(err_code), .rx_overrun(rx_overrun)
  );

  assign starts = {tx_start, chm_start, shr_start, shd_start, cpy_start, ac_start, upd_start};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (starts !== 7'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", {25'd0, starts}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("start_vec", {25'd0, starts}, {25'd0, mon_e.starts});
        check("start_state", {28'd0, state}, {28'd0, mon_e.st});
        check("move_sel", {31'd0, move_sel}, {31'd0, mon_e.ms});
        check("first_move", {31'd0, first_move}, {31'd0, mon_e.fm});
      end
    end
  end

  task automatic drive_done(input int idx, input logic v, input logic f1, input logic f2);
    case (idx)
      P_UPD: upd_done = v;
      P_AC:  begin ac_done = v; ac_changed = f1; end
      P_CPY: begin cpy_done = v; grow_down = f1; grow_right = f2; end
      P_SHD: shd_done = v;
      P_SHR: shr_done = v;
      P_CHM: begin chm_done = v; chm_none = f1; end
      P_TX:  tx_done = v;
      default: ;
    endcase
  endtask

  // Queue the expected start, then wait (bounded) until it appears; returns at that negedge.
  task automatic expect_start(input int idx, input logic ms, input logic fm);
    exp_t e;
    bit   found;
    found    = 1'b0;
    e.starts = 7'(1 << idx);
    e.st     = 4'(idx + 1);
    e.ms     = ms;
    e.fm     = fm;
    exp_q.push_back(e);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (starts[idx]) found = 1'b1;
    end
    check($sformatf("start_seen_p%0d", idx), {31'd0, found}, 32'd1);
  endtask

  task automatic phase(input int idx, input logic f1, input logic f2, input logic ms,
                       input logic fm, input logic early);
    expect_start(idx, ms, fm);
    if (early) begin
      // done inside the start cycle plus an inactive phase's done: both must be ignored
      drive_done(idx, 1'b1, f1, f2);
      shd_done = 1'b1;
      @(posedge clk); #1 drive_done(idx, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 shd_done = 1'b0;
      check("early_done_ignored", {28'd0, state}, 32'(idx + 1));
    end
    @(posedge clk); #1 drive_done(idx, 1'b1, f1, f2);
    @(posedge clk); #1 drive_done(idx, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_edge();
    @(posedge clk); #1 end_receive = 1'b1;
    @(posedge clk); #1 end_receive = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1 check("reset_async_state", {28'd0, state}, 32'd0);
    check("reset_async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    int k;
    // Reset state
    repeat (2) @(posedge clk);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_outputs", {22'd0, starts, move_sel, first_move, busy},  32'd0);
    check("rst_err", {29'd0, err, err_code}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    #1 reset = 1'b1;

    // White, round 1: own first move straight to TX
    color = 1'b0;
    send_edge();
    phase(P_UPD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    phase(P_AC,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    phase(P_CPY, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    phase(P_TX,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_idle", {28'd0, state}, 32'd0);
    check("t1_flags_cleared", {30'd0, first_move, move_sel}, 32'd0);

    // White, round 2: opponent pass, grow down only, then no legal move
    send_edge();
    phase(P_UPD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_AC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_CPY, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_SHD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_CHM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_err_state", {28'd0, state}, 32'd8);
    check("t2_err_code", {29'd0, err, err_code}, 32'd6);
    repeat (4) @(negedge clk);
    check("t2_err_sticky", {28'd0, state}, 32'd8);

    // Black, round 1: full opponent + own pass with both grow flags
    do_reset();
    color = 1'b1;
    send_edge();
    phase(P_UPD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_AC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_AC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_AC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_CPY, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    phase(P_SHD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_SHR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_CHM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(P_UPD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    phase(P_AC,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    phase(P_CPY, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    phase(P_SHR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    phase(P_TX,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_idle", {28'd0, state}, 32'd0);
    check("t3_move_sel_cleared", {31'd0, move_sel}, 32'd0);
    check("t3_no_err", {29'd0, err, err_code}, 32'd0);

    // Reset mid-phase abandons it and issues no start afterwards
    do_reset();
    send_edge();
    expect_start(P_UPD, 1'b0, 1'b0);
    @(posedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    check("t4_still_idle", {28'd0, state}, 32'd0);

    // Auto-complete never settles: error after AC_MAX_ITER passes; overrun on busy edge
    send_edge();
    phase(P_UPD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      if (i == 3) end_receive = 1'b1;
      if (i == 5) end_receive = 1'b0;
      phase(P_AC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("t5_err_state", {28'd0, state}, 32'd8);
    check("t5_err_code", {29'd0, err, err_code}, 32'd5);
    check("t5_overrun", {31'd0, rx_overrun}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);

    // Withheld done: watchdog timeout when enabled, indefinite wait otherwise
    do_reset();
    check("t6_overrun_cleared", {31'd0, rx_overrun}, 32'd0);
    send_edge();
    expect_start(P_UPD, 1'b0, 1'b0);
`ifdef TRAX_WATCHDOG_EN
    k = 0;
    for (int i = 1; i <= 100 && k == 0; i++) begin
      @(negedge clk);
      if (state == 4'd8) k = i;
    end
    check("t6_wd_cycle", 32'(k), 32'd16);
    check("t6_wd_code", {29'd0, err, err_code}, 32'd7);
`else
    k = 0;
    repeat (40) @(negedge clk);
    check("t6_wait_state", {28'd0, state}, 32'd1);
    check("t6_wait_code", {29'd0, err, err_code}, 32'd0);
`endif
    do_reset();
    check("t6_err_cleared", {29'd0, err, err_code}, 32'd0);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trax_turn_sequencer.md
TRAX_TURN_SEQUENCER -- requirements
Module: trax_turn_sequencer

Interface
REQ-001 Parameter AC_MAX_ITER, default 25: maximum auto-complete passes per board update.
REQ-002 Parameter WD_CYCLES, default 4096: per-phase watchdog limit in cycles.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 end_receive  input  1  level from transceiver; its rising edge marks a received move; color is valid with it.
REQ-006 color  input  1  own colour: 0 white, 1 black.
REQ-007 upd_start / upd_done  out/in  1/1  update-copy-map phase handshake.
REQ-008 ac_start / ac_done / ac_changed  out/in/in  1/1/1  auto-complete pass; ac_changed is valid with ac_done.
REQ-009 cpy_start / cpy_done / grow_down / grow_right  out/in/in/in  1 each  copy-to-map; grow flags are valid with cpy_done.
REQ-010 shd_start / shd_done  out/in  1/1  shift-down phase.
REQ-011 shr_start / shr_done  out/in  1/1  shift-right phase.
REQ-012 chm_start / chm_done / chm_none  out/in/in  1 each  choose-move phase; chm_none=1 means no valid move.
REQ-013 tx_start / tx_done  out/in  1/1  transmit own move.
REQ-014 move_sel  output  1  0 = datapath applies received move, 1 = datapath applies chosen move.
REQ-015 first_move  output  1  high during own pass of round 1; datapath applies {plus,0,0}.
REQ-016 state  output  4  current state code; busy  output  1  state != IDLE.
REQ-017 err  output  1  sticky error; err_code  output  2  0 none, 1 AC limit, 2 no move, 3 timeout.
REQ-018 rx_overrun  output  1  sticky; end_receive edge seen while busy.

Function
REQ-019 States and codes: IDLE=0, UPD=1, AC=2, CPY=3, SHD=4, SHR=5, CHM=6, TX=7, ERR=8.
REQ-020 Edge detect: end_receive passes through two registers; an edge is prev=0 and next=1.
REQ-021 Edge in IDLE: round counter (8-bit, saturating) increments.
REQ-022 If new round==1 and color==0: pass=own, first_move=1, move_sel=1, go to UPD.
REQ-023 Otherwise: pass=opp, move_sel=0, go to UPD.
REQ-024 Every *_start is a one-cycle pulse in the first cycle of its state.
REQ-025 A done arriving in the same cycle as its start is ignored; done is sampled from the next cycle on.
REQ-026 UPD done -> AC; iteration counter cleared, then incremented per pass.
REQ-027 AC done with ac_changed=1 -> re-pulse ac_start the next cycle while staying in AC.
REQ-028 AC done with ac_changed=0 -> CPY.
REQ-029 ac_changed=1 when the iteration count equals AC_MAX_ITER -> ERR, err_code=1.
REQ-030 CPY done latches grow_down and grow_right.
REQ-031 After CPY: grow_down -> SHD; else grow_right -> SHR; else go to the post-board state.
REQ-032 SHD done -> SHR if grow_right is latched, else the post-board state.
REQ-033 SHR done -> post-board state.
REQ-034 Post-board state: pass=opp -> CHM; pass=own -> TX.
REQ-035 CHM done with chm_none=0 -> pass=own, move_sel=1, UPD.
REQ-036 CHM done with chm_none=1 -> ERR, err_code=2.
REQ-037 TX done -> IDLE; first_move and move_sel are cleared.
REQ-038 Edge on end_receive outside IDLE: ignored, rx_overrun set, no state change.
REQ-039 Simultaneous done for an inactive phase: ignored.
REQ-040 ERR is terminal until reset; all *_start outputs are held 0.

Reset
REQ-041 reset low (asynchronous) sets: state=IDLE, all outputs 0, round=0, counters 0, latched grow flags 0, edge registers 0.
REQ-042 Reset asserted mid-phase abandons the phase; no start pulse follows reset release until a new edge.

Configuration
REQ-043 TRAX_WATCHDOG_EN defined: a cycle counter clears on each start pulse and counts while waiting for done; reaching WD_CYCLES -> ERR, err_code=3.
REQ-044 TRAX_WATCHDOG_EN undefined: no counter; phases wait indefinitely; err_code never 3.

Verification
REQ-045 color=0, first end_receive edge -> first_move=1; pulses upd, ac (ac_changed=0), cpy (grow 0/0), tx; then IDLE, round=1.
REQ-046 color=1, edge -> UPD, AC x3 (changed 1,1,0), CPY, CHM (none=0), UPD with move_sel=1, AC, CPY, TX -> IDLE.
REQ-047 CPY done with grow_down=1, grow_right=1 -> shd_start, then shr_start after shd_done; state codes 4 then 5.
REQ-048 ac_changed held 1 -> after 25 passes, state=8, err_code=1; edge during busy -> rx_overrun=1.
REQ-049 With TRAX_WATCHDOG_EN and WD_CYCLES=16, withhold upd_done -> ERR at cycle 16, err_code=3; reset low -> IDLE immediately.
